mix_train_seq: RTL
==================

# mix_train_seq

Training-step sequencer for the three-layer mix block. Issues the command levels that the mix block consumes: `zero_grad`, `run_forward` with `state_forward`, `load_backward`, `run_backward` with `state_backward`, and `update`. Steps the block through forward MIX1→MIX3, backward MIX3→MIX1, and optional optimizer update and gradient clear, using the block's `valid_*` strobes. Sits between the top-level training FSM and one mix block instance.

## Interface
- `TO_WIDTH`, 16, width of per-phase watchdog counter; timeout after 2^TO_WIDTH−1 cycles without the awaited valid.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  pulse; begin one training step (ignored unless idle).
- `upd_en`  in  1  sampled with `start`; run update phase after backward.
- `zg_req`  in  1  pulse; standalone gradient clear (ignored unless idle; `start` wins if simultaneous).
- `valid_forward`, `valid_backward`, `valid_update`, `valid_zero_grad`  in  1 each  completion levels from the mix block.
- `run_forward`, `run_backward`, `load_backward`, `update`, `zero_grad`  out  1 each  commands to the mix block.
- `state_forward`, `state_backward`  out  `STATE_LEN`  layer select (`F_MIX1..3`, `B_MIX1..3`).
- `busy`  out  1  high in any non-IDLE state.
- `done`  out  1  one-cycle pulse at step/clear completion.
- `err`  out  1  sticky watchdog flag; cleared by next accepted `start`/`zg_req` or reset.

## Operation
- States: IDLE, FWD, FGAP, LOAD, BWD, BGAP, UPD, ZG, FIN.
- Layer index `lyr` (0..2). Forward uses `F_MIX1+lyr`; backward uses `B_MIX3` down to `B_MIX1`.
- IDLE: `start` → latch `upd_en` into `upd_q`, `lyr`=0, FWD. `zg_req` → ZG.
- FWD: `run_forward`=1. On `valid_forward`: if `lyr`==2 → LOAD, else `lyr`+1, FGAP.
- FGAP: one cycle, `run_forward`=0 (restarts the mix block's forward counter); → FWD.
- LOAD: `load_backward`=1 for exactly one cycle; `lyr`=2; → BWD.
- BWD: `run_backward`=1, `state_backward` per `lyr`. On `valid_backward`: if `lyr`==0 → (`upd_q` ? UPD : FIN), else `lyr`−1, BGAP.
- BGAP: one cycle, `run_backward`=0; → BWD.
- UPD: `update`=1 until `valid_update` → ZG if `MIX_SEQ_AUTO_ZG_EN`, else FIN.
- ZG: `zero_grad`=1 until `valid_zero_grad` → FIN.
- FIN: `done`=1 one cycle; all commands 0; → IDLE.
- Only one of `run_forward`/`run_backward`/`update`/`zero_grad` is high in any cycle.
- `state_forward`/`state_backward` hold last value outside their phases (reset `F_MIX1`/`B_MIX3`).
- Watchdog: counter clears on every state entry and increments in FWD/BWD/UPD/ZG. On reaching all-ones: `err`=1, all commands drop, → IDLE without `done`.
- `start`/`zg_req` while busy are dropped (no queueing).

## Timing
- Reset: all command outputs 0, `busy`=0, `done`=0, `err`=0, state IDLE, `lyr`=0.
- All outputs registered (Moore); no combinational path from inputs to outputs.
- `start` at cycle 0 → `run_forward`=1 from cycle 1.
- Valid seen at cycle n → command low at n+1 (GAP/LOAD/FIN), next command at n+2.
- A valid held high through a GAP is ignored; only valids observed in the matching active state count.
- Reset mid-step: immediate return to IDLE, commands drop asynchronously, no `done`.

## Configuration
- `MIX_SEQ_AUTO_ZG_EN` defined: after UPD completes, ZG runs automatically before FIN (grads cleared for the next batch).
- Undefined: UPD → FIN directly; clearing gradients only via `zg_req`.

## Test plan
- `start`, `upd_en`=0, model valids 5 cycles after each run edge → states F_MIX1,F_MIX2,F_MIX3, one `load_backward` pulse, B_MIX3,B_MIX2,B_MIX1, `done` once; `update` never high.
- `start`, `upd_en`=1 → after B_MIX1, `update` until `valid_update`; with macro, `zero_grad` follows until `valid_zero_grad`, then `done`.
- `zg_req` and `start` in same idle cycle → forward step taken, `zg_req` dropped; `start` pulses during busy → no effect.
- Never assert `valid_backward`, `TO_WIDTH`=4 → `err`=1 after 15 cycles in BWD, `busy`=0, no `done`; next `start` clears `err`.
- `rst_n` low during UPD → `update`=0 immediately, IDLE; subsequent step runs normally.
- Check one-hot commands and a 1-cycle low gap between consecutive `run_forward` phases across the whole step.

Source files
------------

// File: rtl/mix_train_seq.sv
// rtl/mix_train_seq.sv - training-step sequencer for the three-layer mix block
// Optional: MIX_SEQ_AUTO_ZG_EN chains an automatic gradient clear after the update phase.
module mix_train_seq #(
   parameter int TO_WIDTH = 16,
   parameter int STATE_LEN = 3,
   parameter logic [STATE_LEN-1:0] F_MIX1 = 3'd1,
   parameter logic [STATE_LEN-1:0] B_MIX1 = 3'd4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 upd_en,
   input  logic                 zg_req,
   input  logic                 valid_forward,
   input  logic                 valid_backward,
   input  logic                 valid_update,
   input  logic                 valid_zero_grad,
   output logic                 run_forward,
   output logic                 run_backward,
   output logic                 load_backward,
   output logic                 update,
   output logic                 zero_grad,
   output logic [STATE_LEN-1:0] state_forward,
   output logic [STATE_LEN-1:0] state_backward,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_FWD  = 4'd1;
   localparam logic [3:0] S_FGAP = 4'd2;
   localparam logic [3:0] S_LOAD = 4'd3;
   localparam logic [3:0] S_BWD  = 4'd4;
   localparam logic [3:0] S_BGAP = 4'd5;
   localparam logic [3:0] S_UPD  = 4'd6;
   localparam logic [3:0] S_ZG   = 4'd7;
   localparam logic [3:0] S_FIN  = 4'd8;

   // Last count before all-ones: the phase gives up once 2^TO_WIDTH-1 cycles pass without a valid.
   localparam logic [TO_WIDTH-1:0] WD_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

   logic [3:0]           state_q, state_d;
   logic [1:0]           lyr_q, lyr_d;
   logic                 upd_q, upd_d;
   logic                 err_q, err_d;
   logic [TO_WIDTH-1:0]  wd_q, wd_d;
   logic                 timeout;
   logic                 run_fwd_q, run_bwd_q, load_q, upd_cmd_q, zg_cmd_q, busy_q, done_q;
   logic [STATE_LEN-1:0] sf_q, sb_q;

   always_comb begin
      state_d = state_q;
      lyr_d   = lyr_q;
      upd_d   = upd_q;
      err_d   = err_q;
      timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               upd_d   = upd_en;
               lyr_d   = 2'd0;
               err_d   = 1'b0;
               state_d = S_FWD;
            end else if (zg_req) begin
               err_d   = 1'b0;
               state_d = S_ZG;
            end
         end
         S_FWD: begin
            if (valid_forward) begin
               if (lyr_q == 2'd2) begin
                  state_d = S_LOAD;
               end else begin
                  lyr_d   = lyr_q + 2'd1;
                  state_d = S_FGAP;
               end
            end else begin
               timeout = (wd_q == WD_LAST);
            end
         end
         S_FGAP: state_d = S_FWD;
         S_LOAD: begin
            lyr_d   = 2'd2;
            state_d = S_BWD;
         end
         S_BWD: begin
            if (valid_backward) begin
               if (lyr_q == 2'd0) begin
                  state_d = upd_q ? S_UPD : S_FIN;
               end else begin
                  lyr_d   = lyr_q - 2'd1;
                  state_d = S_BGAP;
               end
            end else begin
               timeout = (wd_q == WD_LAST);
            end
         end
         S_BGAP: state_d = S_BWD;
         S_UPD: begin
            if (valid_update) begin
`ifdef MIX_SEQ_AUTO_ZG_EN
               state_d = S_ZG;
`else
               state_d = S_FIN;
`endif
            end else begin
               timeout = (wd_q == WD_LAST);
            end
         end
         S_ZG: begin
            if (valid_zero_grad) state_d = S_FIN;
            else                 timeout = (wd_q == WD_LAST);
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (timeout) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end
      // Every state entry restarts the watchdog; only waiting states ever stay long enough to count.
      wd_d = ((state_d != state_q) || (state_d == S_IDLE)) ? '0 : wd_q + 1'b1;
   end

   // Outputs are registered from the next state so they carry no path from the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         lyr_q     <= 2'd0;
         upd_q     <= 1'b0;
         err_q     <= 1'b0;
         wd_q      <= '0;
         run_fwd_q <= 1'b0;
         run_bwd_q <= 1'b0;
         load_q    <= 1'b0;
         upd_cmd_q <= 1'b0;
         zg_cmd_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sf_q      <= F_MIX1;
         sb_q      <= B_MIX1 + STATE_LEN'(2);
      end else begin
         state_q   <= state_d;
         lyr_q     <= lyr_d;
         upd_q     <= upd_d;
         err_q     <= err_d;
         wd_q      <= wd_d;
         run_fwd_q <= (state_d == S_FWD);
         run_bwd_q <= (state_d == S_BWD);
         load_q    <= (state_d == S_LOAD);
         upd_cmd_q <= (state_d == S_UPD);
         zg_cmd_q  <= (state_d == S_ZG);
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_FIN);
         if (state_d == S_FWD) sf_q <= F_MIX1 + STATE_LEN'(lyr_d);
         if (state_d == S_BWD) sb_q <= B_MIX1 + STATE_LEN'(lyr_d);
      end
   end

   assign run_forward    = run_fwd_q;
   assign run_backward   = run_bwd_q;
   assign load_backward  = load_q;
   assign update         = upd_cmd_q;
   assign zero_grad      = zg_cmd_q;
   assign state_forward  = sf_q;
   assign state_backward = sb_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
endmodule
